// File: rtl/io_pkg.sv
// Shared register map, SR/CR bit positions and FSM encodings for the CPU-to-peripheral I/O controller.
package io_pkg;

    localparam int unsigned REG_DIR = 0;
    localparam int unsigned REG_DOR = 1;
    localparam int unsigned REG_SR  = 2;
    localparam int unsigned REG_CR  = 3;

    localparam int unsigned SR_IN_FULL  = 0;
    localparam int unsigned SR_OUT_BUSY = 1;
    localparam int unsigned SR_WR_ERR   = 2;

    localparam int unsigned CR_IN_EN  = 0;
    localparam int unsigned CR_OUT_EN = 1;
    localparam int unsigned CR_IE_IN  = 2;
    localparam int unsigned CR_IE_OUT = 3;
    localparam int unsigned CR_W      = 4;

    typedef enum logic {
        I_IDLE = 1'b0,
        I_FULL = 1'b1
    } in_state_t;

    typedef enum logic {
        O_IDLE = 1'b0,
        O_PEND = 1'b1
    } out_state_t;

    // Writable CR bits: the interrupt enables exist only when the irq output is built.
    function automatic logic [CR_W-1:0] cr_wmask(input bit irq_en);
        logic [CR_W-1:0] m;
        m = '0;
        m[CR_IN_EN]  = 1'b1;
        m[CR_OUT_EN] = 1'b1;
        m[CR_IE_IN]  = irq_en;
        m[CR_IE_OUT] = irq_en;
        return m;
    endfunction

endpackage

// File: rtl/io_out_chan.sv
// Output channel: holds DOR and sequences the out_valid/out_ready handshake, flagging rejected writes in wr_err.
module io_out_chan
    import io_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dor_we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              out_en,
    input  logic              out_ready,
    input  logic              err_clr,
    output logic [DATA_W-1:0] dor,
    output logic              out_busy,
    output logic              wr_err
);

    out_state_t state;

    assign out_busy = (state == O_PEND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= O_IDLE;
            dor    <= '0;
            wr_err <= 1'b0;
        end else begin
            if (err_clr) begin
                wr_err <= 1'b0;
            end
            // A write is only taken with the channel idle and enabled; anything else is an error,
            // including a write landing on the very cycle the peripheral accepts.
            if (dor_we) begin
                if (state == O_IDLE && out_en) begin
                    dor <= wdata;
                end else begin
                    wr_err <= 1'b1;
                end
            end
            case (state)
                O_IDLE: begin
                    if (dor_we && out_en) begin
                        state <= O_PEND;
                    end
                end
                O_PEND: begin
                    if (out_ready || !out_en) begin
                        state <= O_IDLE;
                    end
                end
                default: state <= O_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/io_bus_ctrl.sv
// Memory-mapped I/O controller: DIR/DOR/SR/CR registers, input handshake FSM and CPU read path.
// Optional level interrupt output is built when IO_IRQ_EN is defined.
module io_bus_ctrl
    import io_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef IO_IRQ_EN
    ,
    output logic              irq
`endif
);

`ifdef IO_IRQ_EN
    localparam logic [CR_W-1:0] CR_WMASK = cr_wmask(1'b1);
`else
    localparam logic [CR_W-1:0] CR_WMASK = cr_wmask(1'b0);
`endif

    in_state_t         in_state;
    logic [DATA_W-1:0] dir;
    logic [CR_W-1:0]   cr;
    logic [DATA_W-1:0] rd_mux;
    logic              rd_acc;
    logic              rd_dir;
    logic              wr_dor;
    logic              wr_sr;
    logic              wr_cr;
    logic              in_full;
    logic              out_busy;
    logic              wr_err;

    // Write has priority: a cycle with both strobes is a write only.
    assign rd_acc  = cpu_re & ~cpu_we;
    assign rd_dir  = rd_acc & (cpu_addr == ADDR_W'(REG_DIR));
    assign wr_dor  = cpu_we & (cpu_addr == ADDR_W'(REG_DOR));
    assign wr_sr   = cpu_we & (cpu_addr == ADDR_W'(REG_SR));
    assign wr_cr   = cpu_we & (cpu_addr == ADDR_W'(REG_CR));
    assign in_full = (in_state == I_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state <= I_IDLE;
            dir      <= '0;
            in_ack   <= 1'b0;
        end else begin
            in_ack <= 1'b0;
            case (in_state)
                I_IDLE: begin
                    if (cr[CR_IN_EN] && in_valid) begin
                        dir      <= in_data;
                        in_ack   <= 1'b1;
                        in_state <= I_FULL;
                    end
                end
                I_FULL: begin
                    if (rd_dir) begin
                        in_state <= I_IDLE;
                    end
                end
                default: in_state <= I_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr <= '0;
        end else if (wr_cr) begin
            cr <= cpu_wdata[CR_W-1:0] & CR_WMASK;
        end
    end

    io_out_chan #(
        .DATA_W (DATA_W)
    ) u_out_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .dor_we    (wr_dor),
        .wdata     (cpu_wdata),
        .out_en    (cr[CR_OUT_EN]),
        .out_ready (out_ready),
        .err_clr   (wr_sr & cpu_wdata[SR_WR_ERR]),
        .dor       (out_data),
        .out_busy  (out_busy),
        .wr_err    (wr_err)
    );

    assign out_valid = out_busy;

    always_comb begin
        rd_mux = '0;
        if (cpu_addr == ADDR_W'(REG_DIR)) begin
            rd_mux = dir;
        end else if (cpu_addr == ADDR_W'(REG_DOR)) begin
            rd_mux = out_data;
        end else if (cpu_addr == ADDR_W'(REG_SR)) begin
            rd_mux[SR_IN_FULL]  = in_full;
            rd_mux[SR_OUT_BUSY] = out_busy;
            rd_mux[SR_WR_ERR]   = wr_err;
        end else begin
            rd_mux[CR_W-1:0] = cr;
        end
    end

    // --- read response stage: data and valid one cycle after the strobe ---
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata  <= '0;
            cpu_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= rd_acc;
            if (rd_acc) begin
                cpu_rdata <= rd_mux;
            end
        end
    end

`ifdef IO_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= (cr[CR_IE_IN] & in_full) |
                   (cr[CR_IE_OUT] & ~out_busy & cr[CR_OUT_EN]);
        end
    end
`endif

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Bench for io_bus_ctrl: directed scenarios plus randomized traffic against a register-level reference model.
module tb_io_bus_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;

`ifdef IO_IRQ_EN
    localparam logic [3:0] CRM = 4'hF;
`else
    localparam logic [3:0] CRM = 4'h3;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_re;
    logic              cpu_we;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ack;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
`ifdef IO_IRQ_EN
    logic              irq;
`endif

    always #5 clk = ~clk;

    io_bus_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ack     (in_ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
`ifdef IO_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: the programmer-visible state after each clock edge.
    logic [31:0] m_dir, m_dor, m_rdata;
    logic [3:0]  m_cr;
    bit          m_full, m_busy, m_err, m_rvalid, m_ack, m_irq;

    function automatic void model_reset();
        m_dir = 0; m_dor = 0; m_rdata = 0; m_cr = 0;
        m_full = 0; m_busy = 0; m_err = 0; m_rvalid = 0; m_ack = 0; m_irq = 0;
    endfunction

    function automatic void model_step();
        bit          rd, wr, in_en, out_en, n_full, n_busy, n_err;
        logic [31:0] n_dir, n_dor;
        rd     = cpu_re && !cpu_we;
        wr     = cpu_we;
        in_en  = m_cr[0];
        out_en = m_cr[1];
        n_full = m_full; n_busy = m_busy; n_err = m_err; n_dir = m_dir; n_dor = m_dor;

        if (rd) begin
            case (cpu_addr)
                2'd0:    m_rdata = m_dir;
                2'd1:    m_rdata = m_dor;
                2'd2:    m_rdata = {29'd0, m_err, m_busy, m_full};
                default: m_rdata = {28'd0, m_cr};
            endcase
        end

        // Input side: a word is taken only into an empty DIR; reading a full DIR empties it.
        if (!m_full) begin
            if (in_en && in_valid) begin
                n_dir  = in_data;
                n_full = 1;
            end
        end else if (rd && cpu_addr == 2'd0) begin
            n_full = 0;
        end

        // Output side: a write is accepted only into an idle, enabled channel.
        if (wr && cpu_addr == 2'd1) begin
            if (!m_busy && out_en) begin
                n_dor  = cpu_wdata;
                n_busy = 1;
            end else begin
                n_err = 1;
            end
        end
        if (m_busy && (out_ready || !out_en)) n_busy = 0;
        if (wr && cpu_addr == 2'd2 && cpu_wdata[2]) n_err = 0;

        m_irq    = (m_cr[2] && m_full) || (m_cr[3] && !m_busy && out_en);
        m_ack    = !m_full && n_full;
        m_rvalid = rd;
        if (wr && cpu_addr == 2'd3) m_cr = cpu_wdata[3:0] & CRM;
        m_full = n_full; m_busy = n_busy; m_err = n_err; m_dir = n_dir; m_dor = n_dor;
    endfunction

    task automatic compare_all();
        check_eq("rvalid", {31'd0, cpu_rvalid}, {31'd0, m_rvalid});
        if (m_rvalid) check_eq("rdata", cpu_rdata, m_rdata);
        check_eq("in_ack", {31'd0, in_ack}, {31'd0, m_ack});
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_busy});
        check_eq("out_data", out_data, m_dor);
`ifdef IO_IRQ_EN
        check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [31:0] d);
        cpu_addr = a;
        cpu_re   = 1'b1;
        tick();
        cpu_re = 1'b0;
        d = cpu_rdata;
    endtask

    logic [31:0] rd;
    int          cnt;

    initial begin
        rst_n = 0; cpu_addr = 0; cpu_re = 0; cpu_we = 0; cpu_wdata = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        model_reset();
        repeat (2) tick();
        check_eq("rst_rdata", cpu_rdata, 32'h0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'h0);
        check_eq("rst_in_ack", {31'd0, in_ack}, 32'h0);
        rst_n = 1;
        tick();

        // Single input word with SR tracking
        cpu_write(2'd3, 32'h3);
        in_data = 32'hA5A5_0001; in_valid = 1;
        tick();
        in_valid = 0;
        check_eq("t1_ack", {31'd0, in_ack}, 32'h1);
        cpu_read(2'd2, rd); check_eq("t1_sr_full", rd, 32'h1);
        cpu_read(2'd0, rd); check_eq("t1_dir", rd, 32'hA5A5_0001);
        cpu_read(2'd2, rd); check_eq("t1_sr_empty", rd, 32'h0);

        // Producer held off while DIR is full
        in_data = 32'h1111_2222; in_valid = 1;
        tick();
        in_data = 32'h3333_4444;
        cnt = 0;
        repeat (4) begin tick(); cnt += int'(in_ack); end
        check_eq("t2_stall", cnt, 0);
        cpu_read(2'd0, rd); check_eq("t2_dir1", rd, 32'h1111_2222);
        tick();
        check_eq("t2_ack2", {31'd0, in_ack}, 32'h1);
        in_valid = 0;
        cpu_read(2'd0, rd); check_eq("t2_dir2", rd, 32'h3333_4444);

        // Output transfer with three wait cycles
        cpu_write(2'd1, 32'h1234);
        check_eq("t3_data", out_data, 32'h1234);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            cnt += int'(out_valid);
            out_ready = (k == 3);
            tick();
        end
        out_ready = 0;
        check_eq("t3_valid_cycles", cnt, 4);
        cpu_read(2'd2, rd); check_eq("t3_sr", rd, 32'h0);

        // Write while pending is rejected
        cpu_write(2'd1, 32'hAAAA);
        cpu_write(2'd1, 32'hBBBB);
        cpu_read(2'd2, rd); check_eq("t4_sr_err", rd, 32'h6);
        cpu_read(2'd1, rd); check_eq("t4_dor", rd, 32'hAAAA);
        cpu_write(2'd2, 32'h4);
        cpu_read(2'd2, rd); check_eq("t4_sr_clr", rd, 32'h2);

        // Asynchronous reset in the middle of a pending transfer
        rst_n = 0;
        #2;
        model_reset();
        check_eq("t5_out_valid", {31'd0, out_valid}, 32'h0);
        check_eq("t5_out_data", out_data, 32'h0);
        tick(); tick();
        rst_n = 1;
        tick();
        for (int a = 0; a < 4; a++) begin
            cpu_read(a[1:0], rd);
            check_eq("t5_reg_zero", rd, 32'h0);
        end

`ifdef IO_IRQ_EN
        cpu_write(2'd3, 32'h5);
        in_data = 32'hCAFE_0006; in_valid = 1;
        tick();
        in_valid = 0;
        check_eq("t6_irq_lag", {31'd0, irq}, 32'h0);
        tick();
        check_eq("t6_irq_set", {31'd0, irq}, 32'h1);
        cpu_read(2'd0, rd);
        tick();
        check_eq("t6_irq_clr", {31'd0, irq}, 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cpu_addr  = 2'($urandom_range(0, 3));
            cpu_re    = ($urandom_range(0, 99) < 35);
            cpu_we    = ($urandom_range(0, 99) < 20);
            cpu_wdata = $urandom;
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0;
                #1;
                model_reset();
                tick();
                rst_n = 1;
            end
            tick();
        end
        cpu_re = 0; cpu_we = 0; in_valid = 0; out_ready = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
